// File: rtl/axis_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_param_fifo
//  Description : Parameterised single-clock AXI-Stream FIFO, first-word-
//                fall-through, with occupancy count, almost-full/empty
//                flags and a synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_param_fifo #(
    parameter int DATA_WIDTH    = 256,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int CW            = $clog2(DEPTH) + 1
) (
    input  logic                  axis_clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

    // Each entry carries tlast in its top bit alongside the data word.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;
    logic [CW-1:0] count_next;

    // Handshakes use only registered ready/valid, so a read in the same
    // cycle can never open space for a write while full.
    assign wr_fire = s_axis_tvalid && s_axis_tready;
    assign rd_fire = m_axis_tvalid && m_axis_tready;

    // Next occupancy; flush wins over any concurrent transfer.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointers, count and all status outputs are registered from count_next
    // so the flags move in the same cycle as count.
    always_ff @(posedge axis_clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            count         <= count_next;
            s_axis_tready <= (count_next != FULL_LVL);
            m_axis_tvalid <= (count_next != '0);
            almost_full   <= (count_next >= AFULL_LVL);
            almost_empty  <= (count_next <= AEMPTY_LVL);
        end
    end

    // Storage write; a beat offered during flush is dropped.
    always_ff @(posedge axis_clk) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Head entry is presented directly from storage (first-word-fall-through).
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_axis_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_param_fifo
//  Description : Self-checking bench for axis_param_fifo: constant vector
//                table, directed corner sequences and randomized traffic
//                against a queue reference model for three parameter sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: defaults (256 bits, 16 deep)
    logic         a_rst = 1'b0, a_flush = 1'b0, a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_m_tready = 1'b0;
    logic [255:0] a_s_tdata = '0;
    logic         a_s_tready, a_m_tvalid, a_m_tlast, a_af, a_ae;
    logic [255:0] a_m_tdata;
    logic [4:0]   a_count;

    axis_param_fifo u_dut_a (
        .axis_clk(clk), .rst(a_rst), .flush(a_flush),
        .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .s_axis_tdata(a_s_tdata), .s_axis_tlast(a_s_tlast),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tlast(a_m_tlast),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
    );

    // ---------------- instance B: 8 bits, 4 deep
    logic       b_rst = 1'b0, b_flush = 1'b0, b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_m_tready = 1'b0;
    logic [7:0] b_s_tdata = '0;
    logic       b_s_tready, b_m_tvalid, b_m_tlast, b_af, b_ae;
    logic [7:0] b_m_tdata;
    logic [2:0] b_count;

    axis_param_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u_dut_b (
        .axis_clk(clk), .rst(b_rst), .flush(b_flush),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
    );

    // ---------------- instance C: 512 bits, 64 deep
    logic         c_rst = 1'b0, c_flush = 1'b0, c_s_tvalid = 1'b0, c_s_tlast = 1'b0, c_m_tready = 1'b0;
    logic [511:0] c_s_tdata = '0;
    logic         c_s_tready, c_m_tvalid, c_m_tlast, c_af, c_ae;
    logic [511:0] c_m_tdata;
    logic [6:0]   c_count;

    axis_param_fifo #(.DATA_WIDTH(512), .DEPTH(64)) u_dut_c (
        .axis_clk(clk), .rst(c_rst), .flush(c_flush),
        .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
        .s_axis_tdata(c_s_tdata), .s_axis_tlast(c_s_tlast),
        .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
        .m_axis_tdata(c_m_tdata), .m_axis_tlast(c_m_tlast),
        .count(c_count), .almost_full(c_af), .almost_empty(c_ae)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state: a plain queue of {tlast, data}
    logic [512:0] mq[$];
    int    cur_k, cur_depth, cur_af, cur_ae, cur_dw;
    string tag;
    bit    known, rst_flag;

    // values sampled at the start of the most recent step
    logic         act_v, act_r, act_af, act_ae, act_l;
    logic [511:0] act_d;
    int           act_cnt;

    // One clock cycle: sample and check outputs, drive inputs, advance model.
    task automatic step(input bit r, input bit f, input bit v, input logic [511:0] d,
                        input bit l, input bit rdy);
        int           sz;
        bit           push, pop;
        logic [511:0] mask;
        @(negedge clk);
        case (cur_k)
            0: begin
                act_v = a_m_tvalid; act_r = a_s_tready; act_af = a_af; act_ae = a_ae;
                act_l = a_m_tlast; act_d = 512'(a_m_tdata); act_cnt = int'(a_count);
            end
            1: begin
                act_v = b_m_tvalid; act_r = b_s_tready; act_af = b_af; act_ae = b_ae;
                act_l = b_m_tlast; act_d = 512'(b_m_tdata); act_cnt = int'(b_count);
            end
            default: begin
                act_v = c_m_tvalid; act_r = c_s_tready; act_af = c_af; act_ae = c_ae;
                act_l = c_m_tlast; act_d = c_m_tdata; act_cnt = int'(c_count);
            end
        endcase
        sz = mq.size();
        if (known) begin
            chk({tag, ".count"},  act_cnt, sz);
            chk({tag, ".tvalid"}, act_v, sz != 0);
            chk({tag, ".tready"}, act_r, !rst_flag && sz != cur_depth);
            chk({tag, ".afull"},  act_af, sz >= cur_af);
            chk({tag, ".aempty"}, act_ae, sz <= cur_ae);
            if (sz != 0) begin
                chk({tag, ".tdata"}, act_d, mq[0][511:0]);
                chk({tag, ".tlast"}, act_l, mq[0][512]);
            end
        end
        case (cur_k)
            0: begin
                a_rst = r; a_flush = f; a_s_tvalid = v; a_s_tdata = d[255:0];
                a_s_tlast = l; a_m_tready = rdy;
            end
            1: begin
                b_rst = r; b_flush = f; b_s_tvalid = v; b_s_tdata = d[7:0];
                b_s_tlast = l; b_m_tready = rdy;
            end
            default: begin
                c_rst = r; c_flush = f; c_s_tvalid = v; c_s_tdata = d;
                c_s_tlast = l; c_m_tready = rdy;
            end
        endcase
        mask = (cur_dw >= 512) ? '1 : ((512'd1 << cur_dw) - 512'd1);
        if (r) begin
            mq.delete();
            rst_flag = 1'b1;
            known    = 1'b1;
        end else if (known) begin
            if (f) begin
                mq.delete();
            end else begin
                push = v && !rst_flag && (sz != cur_depth);
                pop  = (sz != 0) && rdy;
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back({l, d & mask});
            end
            rst_flag = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic select(input int k, input int depth, input int dw, input string t);
        cur_k = k; cur_depth = depth; cur_dw = dw; tag = t;
        cur_af = depth - 2; cur_ae = 2;
        known = 1'b0; rst_flag = 1'b0;
        mq.delete();
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] x;
        for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    typedef struct {
        bit         r, f, v;
        logic [7:0] d;
        bit         l, rdy;
        int         e_cnt;
        bit         e_v, e_r, e_af, e_ae;
        logic [7:0] e_d;
        bit         e_l;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // inputs, then outputs expected after the following edge
        //           r f v  d     l rdy  cnt v r af ae  d     l
        tbl[0]  = '{1,0,0, 8'h00,0,0,   0, 0,0,0,1, 8'h00,0};
        tbl[1]  = '{0,0,0, 8'h00,0,0,   0, 0,1,0,1, 8'h00,0};
        tbl[2]  = '{0,0,1, 8'hA1,0,0,   1, 1,1,0,1, 8'hA1,0};
        tbl[3]  = '{0,0,1, 8'hA2,1,0,   2, 1,1,0,1, 8'hA1,0};
        tbl[4]  = '{0,0,1, 8'hA3,0,1,   2, 1,1,0,1, 8'hA2,1};
        tbl[5]  = '{0,0,1, 8'hA4,0,0,   3, 1,1,0,0, 8'hA2,1};
        tbl[6]  = '{0,0,0, 8'h00,0,1,   2, 1,1,0,1, 8'hA3,0};
        tbl[7]  = '{0,1,1, 8'hA5,0,1,   0, 0,1,0,1, 8'h00,0};
        tbl[8]  = '{0,0,1, 8'hA6,1,0,   1, 1,1,0,1, 8'hA6,1};
        tbl[9]  = '{0,0,0, 8'h00,0,1,   0, 0,1,0,1, 8'h00,0};
        tbl[10] = '{1,0,1, 8'hA7,0,0,   0, 0,0,0,1, 8'h00,0};
        tbl[11] = '{0,0,0, 8'h00,0,0,   0, 0,1,0,1, 8'h00,0};
        tbl[12] = '{0,0,1, 8'hA8,1,1,   1, 1,1,0,1, 8'hA8,1};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_rst = tbl[i].r; a_flush = tbl[i].f; a_s_tvalid = tbl[i].v;
            a_s_tdata = 256'(tbl[i].d); a_s_tlast = tbl[i].l; a_m_tready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk("tbl.count",  512'(a_count), tbl[i].e_cnt);
            chk("tbl.tvalid", a_m_tvalid, tbl[i].e_v);
            chk("tbl.tready", a_s_tready, tbl[i].e_r);
            chk("tbl.afull",  a_af, tbl[i].e_af);
            chk("tbl.aempty", a_ae, tbl[i].e_ae);
            if (tbl[i].e_v) begin
                chk("tbl.tdata", 512'(a_m_tdata), 512'(tbl[i].e_d));
                chk("tbl.tlast", a_m_tlast, tbl[i].e_l);
            end
        end

        // ---------------- directed sequences on the default instance
        select(0, 16, 256, "def");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle();

        // fill 0x0..0xF with the reader stalled, then drain in order
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 512'(i), i == 15, 1'b0);
        idle();
        chk("fill.count",  act_cnt, 16);
        chk("fill.tready", act_r, 1'b0);
        chk("fill.afull",  act_af, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
            chk("drain.data", act_d, 512'(i));
        end
        idle();
        chk("drain.count",  act_cnt, 0);
        chk("drain.aempty", act_ae, 1'b1);

        // full with simultaneous write and read: only the read is taken
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 512'(16'h100 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 512'h77, 1'b1, 1'b1);
        idle();
        chk("fullrw.count",  act_cnt, 15);
        chk("fullrw.tready", act_r, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();

        // continuous streaming, 100 beats through 16 slots
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b1, 512'(16'h1000 + i), (i % 7) == 0, 1'b1);
            if (i >= 1) begin
                chk("stream.count", act_cnt, 1);
                chk("stream.data",  act_d, 512'(16'h1000 + i - 1));
            end
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();

        // flush at count 9 with a concurrent write
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 512'(16'h200 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 512'hF1, 1'b1, 1'b0);
        chk("flush.count_before", act_cnt, 9);
        idle();
        chk("flush.count",  act_cnt, 0);
        chk("flush.tvalid", act_v, 1'b0);
        step(1'b0, 1'b0, 1'b1, 512'hB0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("flush.next_data", act_d, 512'hB0);
        idle();

        // reset mid-stream at count 5
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 512'(16'h300 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("rstmid.count_before", act_cnt, 5);
        idle();
        chk("rstmid.count",  act_cnt, 0);
        chk("rstmid.tvalid", act_v, 1'b0);
        chk("rstmid.tready", act_r, 1'b0);
        chk("rstmid.aempty", act_ae, 1'b1);
        step(1'b0, 1'b0, 1'b1, 512'hC0, 1'b1, 1'b0);
        chk("rstmid.tready_after", act_r, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rstmid.first_data", act_d, 512'hC0);
        chk("rstmid.first_last", act_l, 1'b1);
        idle();

        // ---------------- randomized traffic on all three parameter sets
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       select(1, 4, 8, "small");
                1:       select(2, 64, 512, "big");
                default: select(0, 16, 256, "def");
            endcase
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            for (int n = 0; n < 1500; n++) begin
                bit r, f, v, l, rdy;
                r   = ($urandom_range(0, 199) == 0);
                f   = ($urandom_range(0, 63) == 0);
                v   = ($urandom_range(0, 3) != 0);
                l   = $urandom_range(0, 1) == 1;
                rdy = (n < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
                step(r, f, v, rnd512(), l, rdy);
            end
            for (int n = 0; n < 70; n++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
            idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/axis_param_fifo.md
AXIS_PARAM_FIFO -- requirements
Module: axis_param_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock `axis_clk`, reset `rst`.
REQ-002 Parameter DATA_WIDTH SHALL default to 256 and set the tdata width in bits.
REQ-003 Parameter DEPTH SHALL default to 16, set the entry count, and be a power of two, minimum 4.
REQ-004 Parameter AFULL_THRESH SHALL default to DEPTH-2 and set the level at which almost_full asserts.
REQ-005 Parameter AEMPTY_THRESH SHALL default to 2 and set the level at which almost_empty asserts.
REQ-006 Parameter CW SHALL be derived as clog2(DEPTH)+1.
REQ-007 Ports SHALL be as follows:
- axis_clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of stored data
- s_axis_tvalid  in  1  write request
- s_axis_tready  out  1  space available
- s_axis_tdata  in  DATA_WIDTH  write data
- s_axis_tlast  in  1  packet end, stored with data
- m_axis_tvalid  out  1  data available
- m_axis_tready  in  1  read request
- m_axis_tdata  out  DATA_WIDTH  head data
- m_axis_tlast  out  1  head tlast
- count  out  CW  occupied entries, 0..DEPTH
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH

Function
REQ-008 Storage SHALL be DEPTH entries of DATA_WIDTH+1 bits, addressed by read/write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-009 The write handshake SHALL fire when s_axis_tvalid && s_axis_tready; the read handshake SHALL fire when m_axis_tvalid && m_axis_tready.
REQ-010 s_axis_tready SHALL equal (count != DEPTH) && !rst, registered from state, with no combinational path from m_axis_tready.
REQ-011 When full, a write SHALL be refused even if a read occurs in the same cycle; tready rises the cycle after the read.
REQ-012 m_axis_tvalid SHALL equal (count != 0), registered.
REQ-013 m_axis_tdata and m_axis_tlast SHALL present the head entry first-word-fall-through; they hold stable while tvalid && !tready.
REQ-014 Latency SHALL be one cycle: data written in cycle N SHALL appear with m_axis_tvalid=1 in cycle N+1 when the FIFO was empty.
REQ-015 On a simultaneous read and write with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-016 count SHALL increment on a write-only cycle, decrement on a read-only cycle, and never exceed DEPTH or go below 0.
REQ-017 almost_full and almost_empty SHALL be registered and SHALL track count in the same cycle that count updates.
REQ-018 flush=1 SHALL set pointers and count to 0 at the next edge, taking priority over any write or read in that cycle.
REQ-019 The write or read in a flush cycle SHALL be discarded, and no beat accepted during flush SHALL appear on the output.
REQ-020 m_axis_tdata SHALL be don't-care while m_axis_tvalid=0.
REQ-021 The block SHALL preserve tlast bit-exact per beat and SHALL NOT perform packet-level gating.

Reset
REQ-022 While rst=1 at an edge, count, pointers, m_axis_tvalid, s_axis_tready and almost_full SHALL be 0.
REQ-023 While rst=1 at an edge, almost_empty SHALL be 1.
REQ-024 s_axis_tready SHALL become 1 in the first cycle after rst deasserts.
REQ-025 Reset mid-operation SHALL discard all stored data without emitting any further beat.
REQ-026 Memory contents SHALL NOT require reset.

Verification
REQ-027 Fill/drain (DEPTH=16): write 16 beats 0x0..0xF with m_axis_tready=0 -> count=16, s_axis_tready=0 and almost_full=1; then drain -> data 0x0..0xF in order, count=0, almost_empty=1.
REQ-028 Full plus simultaneous: when full, assert a write and a read in the same cycle -> read accepted, write refused, count=15, tready=1 next cycle.
REQ-029 Streaming: tvalid=tready=1 continuously for 100 beats -> count stays at 1 after the first beat, output equals input delayed by 1 cycle, pointers wrap 6+ times.
REQ-030 Flush: with count=9, assert flush with a concurrent write -> count=0 and m_axis_tvalid=0 next cycle; the flushed beat never appears.
REQ-031 Reset mid-stream: with count=5, assert rst for 1 cycle -> outputs at reset values, tready=1 afterward, next written beat is the first read out.
REQ-032 Parameter sweep: run with DATA_WIDTH=8 and DEPTH=4, and with DATA_WIDTH=512 and DEPTH=64, and random valid/ready plus random tlast -> scoreboard matches with zero loss or duplication.
